// File: rtl/uart_pkg.sv
// Shared UART definitions: the baud-rate table, the baud-index clamp and the
// receiver frame-state encoding. The transmitter and the controller use them too.
package uart_pkg;

    localparam logic [3:0]  BAUD_IDX_MAX = 4'd9;
    localparam int unsigned MIN_BAUD     = 300;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [3:0] clamp_baud_idx(input logic [3:0] idx);
        return (idx > BAUD_IDX_MAX) ? BAUD_IDX_MAX : idx;
    endfunction

    function automatic int unsigned baud_rate(input logic [3:0] idx);
        case (clamp_baud_idx(idx))
            4'd0:    return 300;
            4'd1:    return 1200;
            4'd2:    return 2400;
            4'd3:    return 4800;
            4'd4:    return 9600;
            4'd5:    return 19200;
            4'd6:    return 38400;
            4'd7:    return 57600;
            4'd8:    return 115200;
            default: return 230400;
        endcase
    endfunction

    // Clocks per 16x oversample tick for a given system clock and baud index.
    function automatic int unsigned oversample_div(input int unsigned clk_freq,
                                                   input logic [3:0]  idx);
        return clk_freq / (16 * baud_rate(idx));
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with first-word fall-through read data. A push into a
// full FIFO is accepted only when a pop happens on the same edge.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overrun_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok    = pop_i & ~empty_o;
    assign push_ok   = push_i & (~full_o | pop_ok);
    assign overrun_o = push_i & full_o & ~pop_i;
    // Read data is held at zero while empty so stale entries never leak out.
    assign rdata_o   = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, majority vote on ticks 7/8/9 of each bit,
// received bytes land in a small FIFO read with a single-cycle pop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       rxen_i,
    input  logic [3:0] baud_i,
    input  logic       rx_i,
    input  logic       read_i,
    output logic [7:0] rddata_o,
    output logic       datardy_o,
    output logic       isfull_o,
    output logic       ferr_o,
    output logic       overrun_o,
    output rx_state_e  state_o
);

    localparam int unsigned DIV_MAX = CLK_FREQ / (16 * MIN_BAUD);
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [3:0]       baud_q;
    logic [DIV_W-1:0] div_q, div_d, div_last;
    logic [3:0]       tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       shift_q, shift_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q;
    logic             active, tick, fall, decide, maj, push;
    logic             fifo_empty, fifo_full, fifo_overrun;

    assign active   = en_i & rxen_i;
    assign div_last = DIV_W'(oversample_div(CLK_FREQ, baud_q) - 32'd1);
    assign tick     = (state_q != RX_IDLE) && (div_q == div_last);
    assign fall     = rx_prev_q & ~rx_sync_q;
    assign decide   = tick && (tick_q == 4'd9);
    // Samples from ticks 7 and 8 are stored; the tick-9 sample is the live input.
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) |
                      (samp_q[1] & rx_sync_q);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        if (state_q != RX_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                tick_d = tick_q + 4'd1;
                if (tick_q == 4'd7) samp_d[0] = rx_sync_q;
                if (tick_q == 4'd8) samp_d[1] = rx_sync_q;
            end
        end
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    div_d   = '0;
                    tick_d  = '0;
                end
            end
            RX_START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (decide) begin
                    state_d = RX_IDLE;
                    push    = maj;
                    ferr_d  = ~maj;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        // Disabling drops any partial frame silently.
        if (!active) begin
            state_d = RX_IDLE;
            div_d   = '0;
            tick_d  = '0;
            bit_d   = '0;
            push    = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            baud_q    <= '0;
            div_q     <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            overrun_q <= fifo_overrun;
            if (state_q == RX_IDLE) begin
                baud_q <= clamp_baud_idx(baud_i);
            end
        end
    end

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .wdata_i   (shift_q),
        .pop_i     (read_i),
        .rdata_o   (rddata_o),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .overrun_o (fifo_overrun)
    );

    assign datardy_o = ~fifo_empty;
    assign isfull_o  = fifo_full;
    assign ferr_o    = ferr_q;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at 100 MHz for the nominal 115200 frame, one at
// 10 MHz for everything else, checked against a byte-queue model of the FIFO.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned F_A   = 100000000;
    localparam int unsigned F_B   = 10000000;
    localparam int unsigned DEPTH = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rx_a = 1'b1, read_a = 1'b0;
    logic       rx_b = 1'b1, read_b = 1'b0, en_b = 1'b1, rxen_b = 1'b1;
    logic [3:0] baud_b = 4'd8;
    logic [7:0] rddata_a, rddata_b;
    logic       datardy_a, isfull_a, ferr_a, overrun_a;
    logic       datardy_b, isfull_b, ferr_b, overrun_b;
    rx_state_e  state_a, state_b;

    uart_rx #(.CLK_FREQ(F_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(1'b1), .rxen_i(1'b1), .baud_i(4'd8),
        .rx_i(rx_a), .read_i(read_a), .rddata_o(rddata_a), .datardy_o(datardy_a),
        .isfull_o(isfull_a), .ferr_o(ferr_a), .overrun_o(overrun_a), .state_o(state_a)
    );

    uart_rx #(.CLK_FREQ(F_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .rxen_i(rxen_b), .baud_i(baud_b),
        .rx_i(rx_b), .read_i(read_b), .rddata_o(rddata_b), .datardy_o(datardy_b),
        .isfull_o(isfull_b), .ferr_o(ferr_b), .overrun_o(overrun_b), .state_o(state_b)
    );

    // pulse monitors: count cycles each pulse output is high
    int ferr_cnt_a = 0, ferr_cnt_b = 0, ovr_cnt_b = 0;
    always @(negedge clk) begin
        if (ferr_a)    ferr_cnt_a++;
        if (ferr_b)    ferr_cnt_b++;
        if (overrun_b) ovr_cnt_b++;
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int ferr_snap, ovr_snap;
    int unsigned rates[10] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_clks(input int unsigned f, input int unsigned idx);
        int unsigned k;
        k = (idx > 9) ? 9 : idx;
        return 16 * int'(f / (16 * rates[k]));
    endfunction

    // driver tasks
    task automatic drive_rx(input bit to_a, input logic v, input int n);
        if (to_a) rx_a = v;
        else      rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit to_a, input logic [7:0] b, input logic stop, input int bc);
        drive_rx(to_a, 1'b0, bc);
        for (int i = 0; i < 8; i++) drive_rx(to_a, b[i], bc);
        drive_rx(to_a, stop, bc);
        drive_rx(to_a, 1'b1, 0);
    endtask

    task automatic snap();
        ferr_snap = ferr_cnt_b;
        ovr_snap  = ovr_cnt_b;
    endtask

    task automatic post_frame(input logic [7:0] b, input logic stop, input string tag);
        int exp_ferr, exp_ovr;
        repeat (4) @(negedge clk);
        exp_ferr = 0;
        exp_ovr  = 0;
        if (!stop)                       exp_ferr = 1;
        else if (exp_q.size() < DEPTH)   exp_q.push_back(b);
        else                             exp_ovr = 1;
        check({tag, " ferr"}, ferr_cnt_b - ferr_snap, exp_ferr);
        check({tag, " overrun"}, ovr_cnt_b - ovr_snap, exp_ovr);
        check({tag, " datardy"}, datardy_b, exp_q.size() != 0);
        check({tag, " isfull"}, isfull_b, exp_q.size() == DEPTH);
        if (exp_q.size() != 0) check({tag, " rddata"}, rddata_b, exp_q[0]);
    endtask

    task automatic frame_b(input logic [7:0] b, input logic stop, input int bc, input string tag);
        snap();
        send(1'b0, b, stop, bc);
        post_frame(b, stop, tag);
    endtask

    task automatic read_b_one(input string tag);
        if (exp_q.size() != 0) check({tag, " head"}, rddata_b, exp_q[0]);
        read_b = 1'b1;
        @(negedge clk);
        read_b = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check({tag, " datardy after read"}, datardy_b, exp_q.size() != 0);
        if (exp_q.size() != 0) check({tag, " next head"}, rddata_b, exp_q[0]);
    endtask

    initial begin
        int bc;
        logic [7:0] rb;
        logic       rs;
        logic [3:0] bidx;
        int         nrd;

        // reset values
        repeat (5) @(negedge clk);
        check("rst datardy", datardy_b, 1'b0);
        check("rst isfull", isfull_b, 1'b0);
        check("rst ferr", ferr_b, 1'b0);
        check("rst overrun", overrun_b, 1'b0);
        check("rst rddata", rddata_b, 8'h00);
        check("rst state", 32'(state_b), 32'(RX_IDLE));
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // nominal 100 MHz / 115200 frame
        check("a bit clocks", bit_clks(F_A, 8), 864);
        send(1'b1, 8'hA5, 1'b1, bit_clks(F_A, 8));
        repeat (4) @(negedge clk);
        check("a datardy", datardy_a, 1'b1);
        check("a rddata", rddata_a, 8'hA5);
        check("a ferr", ferr_cnt_a, 0);
        read_a = 1'b1;
        @(negedge clk);
        read_a = 1'b0;
        check("a datardy after read", datardy_a, 1'b0);

        bc = bit_clks(F_B, 8);
        frame_b(8'hA5, 1'b1, bc, "b A5");
        read_b_one("b A5");

        // 3/16-bit glitch: false start
        snap();
        drive_rx(1'b0, 1'b0, 3 * bc / 16);
        drive_rx(1'b0, 1'b1, 2 * bc);
        check("glitch state", 32'(state_b), 32'(RX_IDLE));
        check("glitch datardy", datardy_b, 1'b0);
        check("glitch ferr", ferr_cnt_b - ferr_snap, 0);

        // bad stop bit
        frame_b(8'h3C, 1'b0, bc, "b 3C badstop");

        // fill past depth
        for (int i = 1; i <= 5; i++) frame_b(8'(i), 1'b1, bc, $sformatf("fill %0d", i));
        for (int i = 0; i < 4; i++) read_b_one("drain fill");
        read_b_one("read empty");

        // reset at data bit 3 of 0xFF, with a byte already queued
        frame_b(8'h77, 1'b1, bc, "pre-reset");
        drive_rx(1'b0, 1'b0, bc);
        drive_rx(1'b0, 1'b1, 3 * bc + bc / 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid rst datardy", datardy_b, 1'b0);
        check("mid rst isfull", isfull_b, 1'b0);
        check("mid rst ferr", ferr_b, 1'b0);
        check("mid rst overrun", overrun_b, 1'b0);
        check("mid rst rddata", rddata_b, 8'h00);
        exp_q.delete();
        rst = 1'b0;
        drive_rx(1'b0, 1'b1, 6 * bc);
        frame_b(8'h12, 1'b1, bc, "post-reset 12");
        read_b_one("post-reset 12");

        // disable mid-frame: partial frame dropped without FERR
        snap();
        fork
            send(1'b0, 8'h55, 1'b1, bc);
            begin
                repeat (4 * bc) @(negedge clk);
                en_b = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("disable state", 32'(state_b), 32'(RX_IDLE));
        check("disable datardy", datardy_b, 1'b0);
        check("disable ferr", ferr_cnt_b - ferr_snap, 0);
        en_b = 1'b1;
        repeat (4) @(negedge clk);

        // baud change mid-frame takes effect on the next frame
        snap();
        fork
            send(1'b0, 8'hC3, 1'b1, bc);
            begin
                repeat (5 * bc) @(negedge clk);
                baud_b = 4'd4;
            end
        join
        post_frame(8'hC3, 1'b1, "baud old rate");
        frame_b(8'h5A, 1'b1, bit_clks(F_B, 4), "baud new rate");
        read_b_one("baud old");
        read_b_one("baud new");

        // randomized frames, rates (index 12 clamps to 9), stop bits and reads
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 3))
                0:       bidx = 4'd7;
                1:       bidx = 4'd8;
                2:       bidx = 4'd9;
                default: bidx = 4'd12;
            endcase
            baud_b = bidx;
            repeat (4) @(negedge clk);
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            frame_b(rb, rs, bit_clks(F_B, 32'(bidx)), $sformatf("rand %0d", n));
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) read_b_one("rand read");
        end
        while (exp_q.size() != 0) read_b_one("final drain");
        check("final datardy", datardy_b, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
